// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN call scheduler for a 3-floor elevator car controller
module elevator_call_scheduler #(
    parameter int WAIT_MAX = 32,
    parameter int CW       = 6
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [2:0] Btn,
    input  logic       FLR1,
    input  logic       FLR2,
    input  logic       FLR3,
    input  logic       Door,
    output logic [2:0] Req,
    output logic [2:0] Pend,
    output logic       Dir,
    output logic       Err
);
    typedef enum logic [1:0] {IDLE, SERVE, CLOSE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    btn_prev;
    logic [2:0]    flr;
    logic          f_valid;
    int            f_idx;
    logic [2:0]    press;
    logic [2:0]    clr;
    logic          retire;
    logic          timeout;
    logic [2:0]    tgt;
    logic          tgt_dir;
    logic          found;

    assign flr     = {FLR3, FLR2, FLR1};
    assign f_valid = (flr == 3'b001) || (flr == 3'b010) || (flr == 3'b100);

    always_comb begin
        f_idx = 0;
        if (flr == 3'b010) f_idx = 1;
        if (flr == 3'b100) f_idx = 2;
    end

    // A press at the floor whose door is already open is swallowed.
    assign press   = Btn & ~btn_prev & ~(Door ? flr : 3'b000);
    assign retire  = (state == SERVE) && Door && ((flr & Req) != 3'b000);
    assign timeout = (state == SERVE) && !retire && (cnt == CW'(WAIT_MAX - 1));
    assign clr     = (retire || timeout) ? Req : 3'b000;

    // SCAN: keep sweeping in Dir, reverse only when nothing lies ahead.
    always_comb begin
        tgt     = 3'b000;
        tgt_dir = Dir;
        found   = 1'b0;
        if (Dir) begin
            for (int i = 0; i < 3; i++)
                if (!found && Pend[i] && i >= f_idx) begin
                    tgt[i] = 1'b1;
                    found  = 1'b1;
                end
            for (int i = 2; i >= 0; i--)
                if (!found && Pend[i] && i < f_idx) begin
                    tgt[i]  = 1'b1;
                    tgt_dir = 1'b0;
                    found   = 1'b1;
                end
        end else begin
            for (int i = 2; i >= 0; i--)
                if (!found && Pend[i] && i <= f_idx) begin
                    tgt[i] = 1'b1;
                    found  = 1'b1;
                end
            for (int i = 0; i < 3; i++)
                if (!found && Pend[i] && i > f_idx) begin
                    tgt[i]  = 1'b1;
                    tgt_dir = 1'b1;
                    found   = 1'b1;
                end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            btn_prev <= 3'b000;
            Req      <= 3'b000;
            Pend     <= 3'b000;
            Dir      <= 1'b1;
            Err      <= 1'b0;
        end else begin
            btn_prev <= Btn;
            Err      <= 1'b0;
            // Clearing a served/dropped call beats a same-cycle press of that floor.
            Pend     <= (Pend | press) & ~clr;
            case (state)
                IDLE: begin
                    Req <= 3'b000;
                    if (Pend != 3'b000 && f_valid && !Door) begin
                        Req   <= tgt;
                        Dir   <= tgt_dir;
                        cnt   <= '0;
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    cnt <= cnt + 1'b1;
                    if (retire) begin
                        Req   <= 3'b000;
                        state <= CLOSE;
                    end else if (timeout) begin
                        Req   <= 3'b000;
                        Err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                CLOSE: begin
                    Req <= 3'b000;
                    if (!Door) state <= IDLE;
                end
                default: begin
                    Req   <= 3'b000;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - directed-vector bench for elevator_call_scheduler
module tb_elevator_call_scheduler;
    logic       clk = 1'b0;
    logic       Reset;
    logic [2:0] Btn;
    logic       FLR1, FLR2, FLR3;
    logic       Door;
    logic [2:0] Req;
    logic [2:0] Pend;
    logic       Dir;
    logic       Err;

    int vectors = 0;
    int miscompares = 0;

    elevator_call_scheduler #(.WAIT_MAX(8), .CW(4)) dut (
        .clk(clk), .Reset(Reset), .Btn(Btn),
        .FLR1(FLR1), .FLR2(FLR2), .FLR3(FLR3), .Door(Door),
        .Req(Req), .Pend(Pend), .Dir(Dir), .Err(Err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_floor(input int n);
        FLR1 = (n == 1);
        FLR2 = (n == 2);
        FLR3 = (n == 3);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Btn = 3'b000; Door = 1'b0; set_floor(1);
        step();
        Reset = 1'b0;
        vectors++;
        if (Req !== 3'b000 || Pend !== 3'b000 || Dir !== 1'b1 || Err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: Req=%b Pend=%b Dir=%b Err=%b, required 000 000 1 0", Req, Pend, Dir, Err);
        end
    endtask

    task automatic test_basic_trip();
        Btn = 3'b100; step();
        vectors++;
        if (Pend !== 3'b100 || Req !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_pend: Pend=%b Req=%b, required 100 000", Pend, Req);
        end
        Btn = 3'b000; step();
        vectors++;
        if (Req !== 3'b100 || Dir !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_req: Req=%b Dir=%b, required 100 1", Req, Dir);
        end
        set_floor(3); Door = 1'b1; step();
        vectors++;
        if (Pend !== 3'b000 || Req !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_retire: Pend=%b Req=%b, required 000 000", Pend, Req);
        end
        Door = 1'b0; step(); step();
        vectors++;
        if (Req !== 3'b000 || Dir !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_idle: Req=%b Dir=%b, required 000 1", Req, Dir);
        end
    endtask

    task automatic test_scan();
        set_floor(2); Btn = 3'b101; step();
        Btn = 3'b000;
        vectors++;
        if (Pend !== 3'b101) begin
            miscompares++;
            $display("FAIL scan_pend: Pend=%b, required 101", Pend);
        end
        step();
        vectors++;
        if (Req !== 3'b100 || Dir !== 1'b1) begin
            miscompares++;
            $display("FAIL scan_first: Req=%b Dir=%b, required 100 1", Req, Dir);
        end
        set_floor(3); Door = 1'b1; step();
        vectors++;
        if (Pend !== 3'b001 || Req !== 3'b000) begin
            miscompares++;
            $display("FAIL scan_retire: Pend=%b Req=%b, required 001 000", Pend, Req);
        end
        Door = 1'b0; step();
        vectors++;
        if (Req !== 3'b000) begin
            miscompares++;
            $display("FAIL scan_close: Req=%b, required 000", Req);
        end
        step();
        vectors++;
        if (Req !== 3'b001 || Dir !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_reverse: Req=%b Dir=%b, required 001 0", Req, Dir);
        end
        set_floor(1); Door = 1'b1; step();
        Door = 1'b0; step();
        vectors++;
        if (Pend !== 3'b000 || Req !== 3'b000) begin
            miscompares++;
            $display("FAIL scan_done: Pend=%b Req=%b, required 000 000", Pend, Req);
        end
    endtask

    task automatic test_open_door();
        Door = 1'b1; Btn = 3'b001; step();
        vectors++;
        if (Pend !== 3'b000) begin
            miscompares++;
            $display("FAIL open_door_press: Pend=%b, required 000", Pend);
        end
        Door = 1'b0; step(); step();
        vectors++;
        if (Pend !== 3'b000 || Req !== 3'b000) begin
            miscompares++;
            $display("FAIL held_button: Pend=%b Req=%b, required 000 000", Pend, Req);
        end
        Btn = 3'b000; step();
    endtask

    task automatic test_timeout();
        Btn = 3'b010; step();
        Btn = 3'b000; step();
        vectors++;
        if (Req !== 3'b010 || Dir !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_req: Req=%b Dir=%b, required 010 1", Req, Dir);
        end
        for (int i = 1; i < 8; i++) begin
            step();
            vectors++;
            if (Req !== 3'b010 || Err !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_hold[%0d]: Req=%b Err=%b, required 010 0", i, Req, Err);
            end
        end
        // Re-press the timing-out floor (clear must win) plus floor 1 (must set).
        Btn = 3'b011; step();
        vectors++;
        if (Err !== 1'b1 || Req !== 3'b000 || Pend !== 3'b001) begin
            miscompares++;
            $display("FAIL timeout_drop: Err=%b Req=%b Pend=%b, required 1 000 001", Err, Req, Pend);
        end
        Btn = 3'b000; step();
        vectors++;
        if (Err !== 1'b0 || Req !== 3'b001 || Dir !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_pulse: Err=%b Req=%b Dir=%b, required 0 001 1", Err, Req, Dir);
        end
        Door = 1'b1; step();
        Door = 1'b0; step();
        vectors++;
        if (Pend !== 3'b000 || Req !== 3'b000) begin
            miscompares++;
            $display("FAIL timeout_cleanup: Pend=%b Req=%b, required 000 000", Pend, Req);
        end
    endtask

    task automatic test_hold_req();
        Btn = 3'b100; step();
        Btn = 3'b000; step();
        Btn = 3'b010; step();
        Btn = 3'b000;
        vectors++;
        if (Pend !== 3'b110 || Req !== 3'b100) begin
            miscompares++;
            $display("FAIL hold_new_call: Pend=%b Req=%b, required 110 100", Pend, Req);
        end
        step(); step();
        vectors++;
        if (Req !== 3'b100) begin
            miscompares++;
            $display("FAIL hold_stable: Req=%b, required 100", Req);
        end
        set_floor(3); Door = 1'b1; step();
        vectors++;
        if (Pend !== 3'b010 || Req !== 3'b000) begin
            miscompares++;
            $display("FAIL hold_retire: Pend=%b Req=%b, required 010 000", Pend, Req);
        end
        Door = 1'b0; step(); step();
        vectors++;
        if (Req !== 3'b010 || Dir !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_next: Req=%b Dir=%b, required 010 0", Req, Dir);
        end
        set_floor(2); Door = 1'b1; step();
        Door = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        Btn = 3'b101; step();
        Btn = 3'b000; step();
        vectors++;
        if (Pend !== 3'b101 || Req !== 3'b001 || Dir !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_setup: Pend=%b Req=%b Dir=%b, required 101 001 0", Pend, Req, Dir);
        end
        Reset = 1'b1; step();
        Reset = 1'b0;
        vectors++;
        if (Req !== 3'b000 || Pend !== 3'b000 || Dir !== 1'b1 || Err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: Req=%b Pend=%b Dir=%b Err=%b, required 000 000 1 0", Req, Pend, Dir, Err);
        end
        FLR1 = 1'b1; FLR2 = 1'b1; FLR3 = 1'b0;
        Btn = 3'b101; step();
        Btn = 3'b000;
        vectors++;
        if (Pend !== 3'b101) begin
            miscompares++;
            $display("FAIL invalid_floor_pend: Pend=%b, required 101", Pend);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (Req !== 3'b000 || Dir !== 1'b1) begin
                miscompares++;
                $display("FAIL invalid_floor_idle[%0d]: Req=%b Dir=%b, required 000 1", i, Req, Dir);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_trip();
        test_scan();
        test_open_door();
        test_timeout();
        test_hold_req();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Request-side companion to the 3-floor elevator car controller. Captures button presses for floors 1–3 and holds them as pending calls.
- Picks the next floor to serve with a direction-preserving (SCAN) policy, drives the controller's one-hot Req bus, and retires each call when the car reports the door open at that floor.
- Sits between the button panel and the car controller; consumes the controller's FLR1..FLR3 and Door outputs.

Parameters:
- WAIT_MAX, 32, cycles allowed from issuing a Req to seeing Door=1 at the target floor before the call is dropped.
- CW, 6, width of the timeout counter; must satisfy 2^CW > WAIT_MAX.

Ports:
- clk  input  1  system clock, rising-edge.
- Reset  input  1  synchronous, active-high reset.
- Btn  input  3  raw call buttons, bit n = floor n, level-sensitive, synchronous to clk.
- FLR1  input  1  car at floor 1, from controller.
- FLR2  input  1  car at floor 2, from controller.
- FLR3  input  1  car at floor 3, from controller.
- Door  input  1  door open, from controller.
- Req  output  3  one-hot floor request to controller, 000 = none.
- Pend  output  3  pending-call lamps, bit n = floor n.
- Dir  output  1  current sweep direction, 1 = up, 0 = down.
- Err  output  1  one-cycle pulse when a call is dropped on timeout.

Behaviour:
- All outputs are registered. Reset values: Req=000, Pend=000, Dir=1, Err=0, state=IDLE, counter=0, Btn history=000. Reset takes effect at the clock edge where Reset=1 and overrides every other event, including an in-flight Req.
- Press capture:
  - Btn is edge-detected against its previous-cycle value. A 0→1 edge on bit n sets Pend[n] at that edge.
  - A held button does not re-arm.
  - The press is ignored if Door=1 and FLRn=1 in the same cycle, because that floor is already open.
- Current floor F:
  - Valid only when exactly one of FLR1..FLR3 is 1. Otherwise F is invalid.
  - While F is invalid, the scheduler does not leave IDLE.
- Target selection (combinational, from Pend, F, Dir):
  - Dir=1: pick the lowest pending floor >= F. If none exists, pick the highest pending floor < F and flip Dir to 0.
  - Dir=0: mirror image. Pick the highest pending floor <= F. If none exists, pick the lowest pending floor > F and flip Dir to 1.
  - A call at F is always chosen first.
- State machine:
  - IDLE:
    - Req=000.
    - If Pend≠000, F is valid and Door=0: at the next edge, load Req with the one-hot target, update Dir, clear the counter and go to SERVE.
  - SERVE:
    - Req is held stable; it is never changed mid-trip, even if a closer call arrives.
    - The counter increments each cycle.
    - If Door=1 and the FLR bit matching Req is 1: at that edge, clear Pend for that floor, set Req=000 and go to CLOSE.
    - Else if the counter reaches WAIT_MAX: clear that Pend bit, set Req=000, pulse Err=1 for one cycle and go to IDLE.
  - CLOSE:
    - Req=000.
    - When Door=0, go to IDLE.
    - New presses continue to latch, except presses at the open floor.
- Simultaneous events:
  - If a press edge and a retire (or timeout) hit the same Pend bit in the same cycle, the clear wins.
  - Presses on other bits set normally in the same cycle.
- Latency:
  - From the press edge, Pend is visible 1 cycle later.
  - From IDLE with a call pending, Req is asserted 1 cycle later.
  - From the door-open observation at the target, Pend clears and Req drops 1 cycle later.
- Req is never a non-one-hot value other than 000.

Test Plan:
- Reset, car at floor 1, pulse Btn=100 -> Pend=100 next cycle, Req=100 the cycle after, Dir=1. Model the car reaching FLR3=1 with Door=1 -> Pend=000, Req=000; Door=0 -> IDLE.
- Car at floor 2, Dir=1, press floors 1 and 3 in the same cycle -> Req=100 first. After retire and door close, Req=001 and Dir=0.
- Car at floor 1, door open (Door=1, FLR1=1), press Btn=001 -> Pend stays 000. Hold Btn high after the door closes -> no new call.
- WAIT_MAX=8: issue Req=010 with the car never arriving -> after 8 cycles Err pulses exactly 1 cycle, Pend[2]=0, Req=000, state IDLE.
- In SERVE with Req=100, press Btn=010 -> Pend=110 but Req stays 100 until floor 3 is retired. Then Req=010 with Dir=0.
- Assert Reset during SERVE with Pend=101 -> next cycle Req=000, Pend=000, Dir=1, Err=0. Inputs with FLR1..FLR3 = 110 keep the block in IDLE despite pending calls.
